// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pkg;

    // Fetch FSM states; one read may be outstanding at any time
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HOLD  = 3'd4,
        ST_HALT  = 3'd5
    } ifu_state_t;

    // Next-pc source select
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

    // Bubble presented in place of a faulting fetch (addi x0, x0, 0)
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_pc_sel.sv
// Next-pc mux: hold, sequential +4 (wrapping), or word-aligned redirect target.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
module ifu_pc_sel
    import ifu_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] next_pc
);

    // Select next pc; redirect targets have their low two bits cleared
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_INC:   next_pc = pc + PC_W'(4);
            PC_REDIR: next_pc = redirect_pc & ~PC_W'(3);
            default:  next_pc = pc;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the pc, issues one imem read at a time, hands words to decode.
// Latency: REQ -> WAIT -> HOLD, so at best one instruction every 3 cycles.
// Backpressure: decode stalls in HOLD (no new request); redirects squash in-flight work.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
);

    ifu_state_t      state;
    pc_sel_t         pc_sel;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            req_vld_q;
    logic            hold_q;

    // Redirect wins everywhere except IDLE; otherwise advance only on a clean decode handshake
    always_comb begin
        pc_sel = PC_HOLD;
        if (state != ST_IDLE && redirect_valid) begin
            pc_sel = PC_REDIR;
        end else if (state == ST_HOLD && inst_ready && !inst_fault) begin
            pc_sel = PC_INC;
        end
    end

    ifu_pc_sel #(.PC_W(PC_W)) u_pc_sel (
        .sel         (pc_sel),
        .pc          (pc),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc)
    );

    // Program counter register; the address only moves while no request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC & ~PC_W'(3);
        end else begin
            pc <= next_pc;
        end
    end

    // Fetch FSM with registered request-valid and hold flags derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_vld_q  <= 1'b0;
            hold_q     <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            req_vld_q <= 1'b0;
            hold_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_REQ;
                    req_vld_q <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        // An accepted request under redirect still returns a response to discard
                        state <= redirect_valid ? ST_FLUSH : ST_WAIT;
                    end else begin
                        req_vld_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redirect_valid) begin
                            state     <= ST_REQ;
                            req_vld_q <= 1'b1;
                        end else begin
                            state      <= ST_HOLD;
                            hold_q     <= 1'b1;
                            inst       <= imem_rsp_err ? INST_NOP : imem_rsp_data;
                            inst_pc    <= pc;
                            inst_fault <= imem_rsp_err;
                        end
                    end else if (redirect_valid) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (imem_rsp_valid) begin
                        state     <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        state     <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end else if (inst_ready) begin
                        if (inst_fault) begin
                            state <= ST_HALT;
                        end else begin
                            state     <= ST_REQ;
                            req_vld_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        state     <= ST_REQ;
                        req_vld_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = req_vld_q;
    assign imem_req_addr  = pc;
    // A same-cycle redirect hides the held instruction so decode never consumes it
    assign inst_valid     = hold_q & ~redirect_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ERR_ADDR = 64'h0000_0000_8000_0008;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
        logic        f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_seen = 0;
    int acc_cnt = 0;
    int hs_cnt  = 0;
    int hs_cyc[$];
    int mem_lat = 1;
    int pend_cnt = 0;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    exp_t        exp_q[$];
    logic [63:0] exp_addr_q[$];

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'h0010_0093;
            64'h8000_0004: return 32'h0020_8113;
            64'h8000_1004: return 32'hDEAD_BEEF;
            default:       return {a[15:0], 16'h0513};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_inst(input logic [63:0] a);
        exp_t e;
        e.pc = a;
        e.f  = (a == ERR_ADDR);
        e.w  = e.f ? 32'h0000_0013 : mem_word(a);
        exp_q.push_back(e);
    endtask

    // One clock: observe at negedge, then drive the memory response just after posedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (imem_req_valid) req_seen++;
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                chk("req_align", 64'(imem_req_addr[1:0]), 64'd0);
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL req_unexpected observed=%h expected=none", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, exp_addr_q.pop_front());
                end
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = imem_req_addr;
            end
            if (inst_valid && inst_ready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL inst_unexpected observed=%h pc=%h expected=none", inst, inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_word", 64'(inst), 64'(e.w));
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_fault", 64'(inst_fault), 64'(e.f));
                end
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_err   = (pend_addr == ERR_ADDR);
                imem_rsp_data  = imem_rsp_err ? 32'hFFFF_FFFF : mem_word(pend_addr);
                pend           = 1'b0;
            end
        end
    endtask

    task automatic run_until_hs(input int n);
        int target;
        target = hs_cnt + n;
        for (int i = 0; i < 60 && hs_cnt < target; i++) tick();
        chk("hs_count", 64'(hs_cnt), 64'(target));
    endtask

    task automatic run_until_acc(input int n);
        int target;
        target = acc_cnt + n;
        for (int i = 0; i < 60 && acc_cnt < target; i++) tick();
        chk("acc_count", 64'(acc_cnt), 64'(target));
    endtask

    task automatic redirect_pulse(input logic [63:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int base_req;
        int base_hs;
        logic [31:0] w_hold;
        logic [63:0] pc_hold;

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_fault", 64'(inst_fault), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming fetch: two good words then an access fault at +8
        exp_addr_q.push_back(RST_PC);
        exp_addr_q.push_back(RST_PC + 64'd4);
        exp_addr_q.push_back(ERR_ADDR);
        push_inst(RST_PC);
        push_inst(RST_PC + 64'd4);
        push_inst(ERR_ADDR);
        run_until_hs(3);
        if (hs_cyc.size() >= 3) begin
            chk("hs_spacing_a", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            chk("hs_spacing_b", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end

        // Halted after the faulting handshake: no requests, no instructions
        base_req = req_seen;
        base_hs  = hs_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("halt_no_req", 64'(req_seen - base_req), 64'd0);
        chk("halt_no_hs", 64'(hs_cnt - base_hs), 64'd0);
        chk("halt_inst_valid", 64'(inst_valid), 64'd0);

        // Redirect out of HALT, then stall decode for 5 cycles in HOLD
        inst_ready = 1'b0;
        exp_addr_q.push_back(64'h8000_1000);
        push_inst(64'h8000_1000);
        redirect_pulse(64'h8000_1000);
        for (int i = 0; i < 20 && !inst_valid; i++) tick();
        chk("stall_valid", 64'(inst_valid), 64'd1);
        base_req = req_seen;
        w_hold   = inst;
        pc_hold  = inst_pc;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_inst", 64'(inst), 64'(mem_word(64'h8000_1000)));
        chk("stall_inst_stable", 64'(inst), 64'(w_hold));
        chk("stall_pc", inst_pc, 64'h8000_1000);
        chk("stall_pc_stable", inst_pc, pc_hold);
        chk("stall_no_req", 64'(req_seen - base_req), 64'd0);
        chk("stall_still_valid", 64'(inst_valid), 64'd1);

        // Release decode; next request at pc+4 gets a slow response that a redirect squashes
        exp_addr_q.push_back(64'h8000_1004);
        mem_lat    = 3;
        inst_ready = 1'b1;
        run_until_hs(1);
        run_until_acc(1);
        mem_lat = 1;
        exp_addr_q.push_back(64'h8000_0100);
        push_inst(64'h8000_0100);
        redirect_pulse(64'h8000_0102);
        run_until_hs(1);

        // Redirect coinciding with the response: word dropped
        exp_addr_q.push_back(64'h8000_0104);
        run_until_acc(1);
        chk("wait_rsp_now", 64'(imem_rsp_valid), 64'd1);
        exp_addr_q.push_back(64'h8000_2000);
        base_hs = hs_cnt;
        redirect_pulse(64'h8000_2000);
        run_until_acc(1);
        tick();
        chk("hold_before_redir", 64'(inst_valid), 64'd1);
        chk("hold_pc_before_redir", inst_pc, 64'h8000_2000);

        // Redirect coinciding with inst_ready: instruction masked and dropped
        exp_addr_q.push_back(64'h8000_3004);
        push_inst(64'h8000_3004);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3004;
        #1;
        chk("redir_masks_valid", 64'(inst_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        chk("dropped_no_hs", 64'(hs_cnt - base_hs), 64'd0);
        run_until_hs(1);

        // Asynchronous reset while waiting on memory
        exp_addr_q.push_back(64'h8000_3008);
        mem_lat = 4;
        run_until_acc(1);
        rst = 1'b1;
        #1;
        chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("arst_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
        chk("arst_inst_pc", inst_pc, 64'd0);
        chk("arst_inst_fault", 64'(inst_fault), 64'd0);
        tick();
        tick();
        imem_rsp_valid = 1'b0;
        rst     = 1'b0;
        mem_lat = 1;
        exp_addr_q.push_back(RST_PC);
        push_inst(RST_PC);
        run_until_hs(1);

        chk("exp_inst_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_addr_drained", 64'(exp_addr_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: owns the PC and issues one 32-bit read at a time to instruction memory.
- Presents each fetched instruction, with its PC, to the decode stage over a valid/ready handshake. It is the producer end of the decoder's `inst` input.
- Accepts redirects (branch/jump/trap) from downstream and squashes any fetch still in flight.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- PC_W, 64, PC/address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  PC_W  request address, always 4-byte aligned
- imem_rsp_valid  in  1  read data valid (exactly one response per accepted request, arriving at least 1 cycle later)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault; qualified by imem_rsp_valid
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes the instruction
- inst  out  32  instruction word
- inst_pc  out  PC_W  PC of `inst`
- inst_fault  out  1  instruction fetch access fault (`inst` forced to 32'h0000_0013)
- redirect_valid  in  1  redirect request
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored (treated as 0)

Behaviour:
- States: IDLE, REQ, WAIT, FLUSH, HOLD, HALT. At most one request outstanding.
- Reset (async, any time, including mid-transaction):
  - state=IDLE, pc=RESET_PC.
  - inst=0, inst_pc=0, inst_fault=0.
  - All valid outputs are 0.
  - A response arriving after reset release for a pre-reset request is a memory-side error; it is not required to be handled.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - req_ready & !redirect -> WAIT.
  - req_ready & redirect -> FLUSH, pc<=redirect_pc. The issued request is squashed.
  - !req_ready & redirect -> stay in REQ, pc<=redirect_pc. The address may change only while the request is not accepted.
- WAIT:
  - rsp_valid & !redirect -> HOLD. Capture inst<=rsp_err?32'h13:rsp_data, inst_pc<=pc, inst_fault<=rsp_err.
  - rsp_valid & redirect -> REQ, pc<=redirect_pc. The response is dropped.
  - !rsp_valid & redirect -> FLUSH, pc<=redirect_pc.
- FLUSH:
  - Wait for the stale response and discard it: rsp_valid -> REQ.
  - A redirect here only updates pc; it does not change the state.
- HOLD:
  - inst_valid = !redirect_valid (combinational mask). inst/inst_pc/inst_fault are held stable.
  - redirect -> REQ, pc<=redirect_pc. The instruction is dropped and redirect beats ready.
  - inst_ready & !inst_fault -> REQ, pc<=pc+4.
  - inst_ready & inst_fault -> HALT.
- HALT:
  - No requests, inst_valid=0.
  - Leave only on redirect -> REQ, pc<=redirect_pc.
- PC arithmetic: pc+4 wraps modulo 2^PC_W with no flag.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT, HOLD) with 1-cycle memory and an always-ready decoder.
- imem_rsp_valid outside WAIT/FLUSH is ignored.
- Assertions for the verification bench:
  - imem_req_addr[1:0]==0.
  - imem_req_valid only in REQ.
  - Exactly one inst handshake per non-squashed response.

Decomposition:
- Shared package `ifu_pkg`:
  - state enum (6 states, 3 bits).
  - INST_NOP=32'h0000_0013.
  - default RESET_PC.
- One natural sub-module: `ifu_pc_sel`, the combinational next-pc mux (hold / pc+4 / redirect_pc with [1:0] cleared).

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decoder always ready, words 0x00100093, 0x00208113 -> addrs 0x80000000, 0x80000004; inst_pc matches; handshake every 3rd cycle.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, no new request; ready high -> next request at pc+4.
- Redirect to 0x80000102 asserted while in WAIT; response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never shown; next request address 0x80000100.
- Redirect in the same cycle as rsp_valid, and a separate redirect in the same cycle as inst_ready -> instruction dropped, next fetch at the redirect target.
- rsp_err=1 at 0x80000008 -> inst=0x00000013, inst_fault=1; after handshake no requests for 10 cycles; redirect to 0x80001000 resumes fetch there.
- Assert rst mid-WAIT -> outputs 0 immediately (asynchronously); after release, first request at RESET_PC.
